// File: rtl/sample_hex_formatter_if.sv
// Sample-in / ASCII-out handshake bundle for sample_hex_formatter.
//   i_sample       : 16-bit ADC conversion result
//   i_sample_valid : i_sample is valid
//   o_sample_ready : formatter can accept a sample
//   o_tx_data      : ASCII character offered to the UART TX
//   o_tx_valid     : o_tx_data is valid
//   i_tx_ready     : downstream accepts o_tx_data
//   o_busy         : a line is in progress
// slave  = formatter side, master = producer/consumer side.
interface sample_hex_formatter_if;
    logic [15:0] i_sample;
    logic        i_sample_valid;
    logic        o_sample_ready;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_busy;

    modport slave (
        input  i_sample, i_sample_valid, i_tx_ready,
        output o_sample_ready, o_tx_data, o_tx_valid, o_busy
    );

    modport master (
        output i_sample, i_sample_valid, i_tx_ready,
        input  o_sample_ready, o_tx_data, o_tx_valid, o_busy
    );
endinterface

// File: rtl/sample_hex_formatter.sv
// Formats one 16-bit ADC sample per line as uppercase ASCII hex for a UART TX:
//   ["0x"] d3 d2 d1 d0 [CR] LF
// Parameters:
//   PREFIX_EN : 1 = emit "0x" before the digits
//   EOL_CRLF  : 1 = end lines with CR LF, 0 = LF only
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : sample_hex_formatter_if.slave (sample in, character out, busy)
//
// state | meaning
// IDLE  | waiting for a sample (ready after the first post-reset edge)
// SEND  | offering character idx_q of the latched sample's line
module sample_hex_formatter #(
    parameter bit PREFIX_EN = 1'b1,
    parameter bit EOL_CRLF  = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    sample_hex_formatter_if.slave  bus
);
    localparam int         PFX_LEN  = PREFIX_EN ? 2 : 0;
    localparam int         EOL_LEN  = EOL_CRLF ? 2 : 1;
    localparam int         LEN      = PFX_LEN + 4 + EOL_LEN;
    localparam logic [2:0] LAST_IDX = 3'(LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [15:0] sample_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;
    logic        ready_q;
    logic        busy_q;
    logic [7:0]  next_char_d;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return {4'h0, nib} + ((nib < 4'd10) ? 8'h30 : 8'h37);
    endfunction

    // Character at line position idx for sample smp.
    function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [15:0] smp);
        int         pos;
        int         dig;
        logic [7:0] c;
        pos = int'(idx);
        c   = 8'h0A;
        if (pos < PFX_LEN) begin
            c = (pos == 0) ? 8'h30 : 8'h78;
        end else if (pos < PFX_LEN + 4) begin
            dig = 3 - (pos - PFX_LEN);
            c   = hex_char(smp[4*dig +: 4]);
        end else if (EOL_CRLF && pos == PFX_LEN + 4) begin
            c = 8'h0D;
        end
        return c;
    endfunction

    assign next_char_d = char_at(idx_q + 3'd1, sample_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ready_q && bus.i_sample_valid) begin
                        // First character comes straight from the input so it
                        // is on the bus one cycle after the accept.
                        sample_q   <= bus.i_sample;
                        idx_q      <= 3'd0;
                        tx_data_q  <= char_at(3'd0, bus.i_sample);
                        tx_valid_q <= 1'b1;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SEND: begin
                    if (bus.i_tx_ready) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q      <= 3'd0;
                            tx_data_q  <= 8'h00;
                            tx_valid_q <= 1'b0;
                            ready_q    <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= next_char_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_sample_ready = ready_q;
    assign bus.o_tx_data      = tx_data_q;
    assign bus.o_tx_valid     = tx_valid_q;
    assign bus.o_busy         = busy_q;
endmodule

// File: tb/tb_sample_hex_formatter.sv
// Self-checking bench for sample_hex_formatter: one default instance (a) and
// one PREFIX_EN=0/EOL_CRLF=0 instance (b) sharing stimulus, a queue-based
// reference model per instance checked every cycle, plus literal line checks.
module tb_sample_hex_formatter;
    logic        clk;
    logic        rst_n;
    logic [15:0] samp;
    logic        sv;
    logic        txr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sample_hex_formatter_if ifa ();
    sample_hex_formatter_if ifb ();

    assign ifa.i_sample       = samp;
    assign ifa.i_sample_valid = sv;
    assign ifa.i_tx_ready     = txr;
    assign ifb.i_sample       = samp;
    assign ifb.i_sample_valid = sv;
    assign ifb.i_tx_ready     = txr;

    sample_hex_formatter u_a (.i_clk(clk), .i_rst_n(rst_n), .bus(ifa));
    sample_hex_formatter #(.PREFIX_EN(1'b0), .EOL_CRLF(1'b0)) u_b (.i_clk(clk), .i_rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] e29[8]  = '{8'h30, 8'h78, 8'h31, 8'h41, 8'h32, 8'h46, 8'h0D, 8'h0A};
    logic [7:0] e30[5]  = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h0A};
    logic [7:0] e31[8]  = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
    logic [7:0] e32[16] = '{8'h30, 8'h78, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A,
                            8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    logic [7:0] e33[8]  = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h43, 8'h30, 8'h0D, 8'h0A};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a line is a queue of characters; one character leaves
    // the queue per downstream handshake.
    typedef logic [7:0] bq_t[$];
    bq_t        mq[2];
    bit         m_busy[2]  = '{0, 0};
    bit         m_ready[2] = '{0, 0};
    bit         m_valid[2] = '{0, 0};
    logic [7:0] m_data[2]  = '{8'h00, 8'h00};

    function automatic void build_line(input int d, input logic [15:0] s);
        string hx = "0123456789ABCDEF";
        bit    pfx = (d == 0);
        bit    crlf = (d == 0);
        mq[d].delete();
        if (pfx) begin
            mq[d].push_back(8'h30);
            mq[d].push_back(8'h78);
        end
        for (int n = 3; n >= 0; n--) mq[d].push_back(hx[int'(s[n*4 +: 4])]);
        if (crlf) mq[d].push_back(8'h0D);
        mq[d].push_back(8'h0A);
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_busy[d] = 0; m_ready[d] = 0; m_valid[d] = 0; m_data[d] = 8'h00;
                mq[d].delete();
            end else if (!m_busy[d]) begin
                if (m_ready[d] && sv) begin
                    build_line(d, samp);
                    m_data[d]  = mq[d].pop_front();
                    m_valid[d] = 1; m_busy[d] = 1; m_ready[d] = 0;
                end else begin
                    m_ready[d] = 1;
                end
            end else if (txr) begin
                if (mq[d].size() == 0) begin
                    m_busy[d] = 0; m_valid[d] = 0; m_data[d] = 8'h00; m_ready[d] = 1;
                end else begin
                    m_data[d] = mq[d].pop_front();
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("a.ready", ifa.o_sample_ready, m_ready[0]);
        chk("a.valid", ifa.o_tx_valid, m_valid[0]);
        chk("a.data",  ifa.o_tx_data,  m_data[0]);
        chk("a.busy",  ifa.o_busy,     m_busy[0]);
        chk("b.ready", ifb.o_sample_ready, m_ready[1]);
        chk("b.valid", ifb.o_tx_valid, m_valid[1]);
        chk("b.data",  ifb.o_tx_data,  m_data[1]);
        chk("b.busy",  ifb.o_busy,     m_busy[1]);
    end

    // Log of characters handed to downstream and accept cycles (instance a).
    logic [7:0] gotq[$];
    int         accq[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.o_tx_valid && txr) gotq.push_back(ifa.o_tx_data);
            if (ifa.o_sample_ready && sv) accq.push_back(cyc);
        end
    end

    task automatic wait_idle();
        int n = 0;
        sv = 1'b0;
        txr = 1'b1;
        while ((ifa.o_busy || ifb.o_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {31'b0, ifa.o_busy | ifb.o_busy}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; sv = 1'b0; samp = 16'h0000; txr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.a.ready", ifa.o_sample_ready, 0);
        chk("rst.a.valid", ifa.o_tx_valid, 0);
        chk("rst.a.data",  ifa.o_tx_data, 0);
        chk("rst.a.busy",  ifa.o_busy, 0);
        chk("rst.b.ready", ifb.o_sample_ready, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("rel.ready_before_edge", ifa.o_sample_ready, 0);
        @(negedge clk); chk("rel.ready_after_edge", ifa.o_sample_ready, 1);

        // 0x1A2F on the default instance, no stalls
        @(posedge clk); #1 samp = 16'h1A2F; sv = 1'b1; txr = 1'b1;
        @(posedge clk); #1 sv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("r029.char%0d", k), ifa.o_tx_data, e29[k]);
            chk($sformatf("r029.valid%0d", k), ifa.o_tx_valid, 1);
        end
        @(negedge clk);
        chk("r029.ready_c9", ifa.o_sample_ready, 1);
        chk("r029.valid_c9", ifa.o_tx_valid, 0);

        // 0xFFFF on the no-prefix, LF-only instance
        wait_idle();
        @(posedge clk); #1 samp = 16'hFFFF; sv = 1'b1; txr = 1'b1;
        @(posedge clk); #1 sv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("r030.char%0d", k), ifb.o_tx_data, e30[k]);
        end
        @(negedge clk);
        chk("r030.idle_ready", ifb.o_sample_ready, 1);
        chk("r030.idle_valid", ifb.o_tx_valid, 0);
        chk("r030.idle_data",  ifb.o_tx_data, 0);

        // 0x0000 with downstream ready one cycle in three
        wait_idle();
        gotq.delete();
        @(posedge clk); #1 samp = 16'h0000; sv = 1'b1; txr = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1 sv = 1'b0; txr = (c % 3 == 2);
        end
        chk("r031.count", gotq.size(), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("r031.char%0d", k), gotq[k], e31[k]);

        // new sample held valid during a line
        wait_idle();
        gotq.delete(); accq.delete();
        @(posedge clk); #1 samp = 16'hABCD; sv = 1'b1; txr = 1'b1;
        n = 0;
        while (gotq.size() < 16 && n < 60) begin
            @(posedge clk); #1;
            if (accq.size() >= 1) samp = 16'h1234;
            if (accq.size() >= 2) sv = 1'b0;
            n++;
        end
        sv = 1'b0;
        chk("r032.count", gotq.size(), 16);
        for (int k = 0; k < 16; k++) chk($sformatf("r032.char%0d", k), gotq[k], e32[k]);
        chk("r032.accepts", accq.size(), 2);
        if (accq.size() >= 2) chk("r032.gap", accq[1] - accq[0], 9);

        // reset pulse after the third character
        wait_idle();
        gotq.delete(); accq.delete();
        @(posedge clk); #1 samp = 16'h5A5A; sv = 1'b1; txr = 1'b1;
        n = 0;
        while (gotq.size() < 3 && n < 40) begin
            @(posedge clk); #1;
            if (accq.size() >= 1) sv = 1'b0;
            n++;
        end
        chk("r033.three_sent", gotq.size(), 3);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        gotq.delete(); accq.delete(); samp = 16'h00C0; sv = 1'b1;
        @(negedge clk);
        chk("r033.valid_after_rst", ifa.o_tx_valid, 0);
        chk("r033.data_after_rst",  ifa.o_tx_data, 0);
        chk("r033.busy_after_rst",  ifa.o_busy, 0);
        n = 0;
        while (gotq.size() < 8 && n < 40) begin
            @(posedge clk); #1;
            if (accq.size() >= 1) sv = 1'b0;
            n++;
        end
        wait_idle();
        chk("r033.count", gotq.size(), 8);
        for (int k = 0; k < 8; k++) chk($sformatf("r033.char%0d", k), gotq[k], e33[k]);

        // 1000 back-to-back random lines
        wait_idle();
        accq.delete();
        @(posedge clk); #1 sv = 1'b1; txr = 1'b1; samp = 16'($urandom);
        n = 0;
        while (accq.size() < 1000 && n < 12000) begin
            @(posedge clk); #1 samp = 16'($urandom);
            n++;
        end
        sv = 1'b0;
        chk("r034.lines", {31'b0, accq.size() >= 1000}, 1);
        for (int i = 1; i < accq.size(); i++) chk($sformatf("r034.period%0d", i), accq[i] - accq[i-1], 9);

        // random valid/ready stalls
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            samp = 16'($urandom);
            sv   = 1'($urandom_range(0, 1));
            txr  = 1'($urandom_range(0, 1));
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
